// File: rtl/legup_call_pkg.sv
// Shared types and defaults for the LegUp start/finish call initiator.
//   call_state_t     : initiator FSM state encoding
//   DEF_*            : default parameter values
//   timeout_enabled  : 1 when a nonzero WAIT timeout is configured
package legup_call_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALL = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } call_state_t;

  localparam int DEF_DATA_W         = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_CNT_W          = 16;

  function automatic bit timeout_enabled(input int timeout_cycles);
    return timeout_cycles != 0;
  endfunction

endpackage

// File: rtl/legup_call_timeout.sv
// WAIT-state watchdog for the call initiator.
//   clk, reset : clock, async active-low reset
//   clear      : restart the count at 0 (driven while the call is issued)
//   enable     : count this cycle (driven while waiting for finish)
//   expired    : high in the cycle the count reaches TIMEOUT_CYCLES-1 while enabled
module legup_call_timeout
  import legup_call_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count;

  assign expired = enable && (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/legup_call_initiator.sv
// Caller-side engine for the LegUp custom-Verilog start/finish protocol.
// Takes argument pairs from a valid/ready request port, pulses callee_start
// with registered arguments, waits for callee_finish (same cycle or later,
// optionally bounded by a timeout) and presents the return value on a
// valid/ready response port.
//   clk, reset                        : clock, async active-low reset
//   req_valid/req_ready/req_arg_i/j   : request handshake and arguments
//   callee_start/callee_arg_i/j       : call pulse and held arguments
//   callee_finish/callee_return_val   : completion and result from callee
//   rsp_valid/rsp_ready/rsp_data      : response handshake and result
//   rsp_timeout                       : response is a timeout (data is 0)
//   busy                              : a call is in progress
//   call_count                        : successful calls, wrapping
//
// state | meaning
// IDLE  | ready for a request
// CALL  | start pulse to callee; finish may arrive in this cycle
// WAIT  | waiting for finish or timeout expiry
// DONE  | response presented until rsp_ready
module legup_call_initiator
  import legup_call_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_arg_i,
  input  logic [DATA_W-1:0] req_arg_j,
  output logic              callee_start,
  output logic [DATA_W-1:0] callee_arg_i,
  output logic [DATA_W-1:0] callee_arg_j,
  input  logic              callee_finish,
  input  logic [DATA_W-1:0] callee_return_val,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [CNT_W-1:0]  call_count
);

  call_state_t state, state_next;
  logic        expired;
  logic        accept;
  logic        capture;
  logic        expire;

  generate
    if (timeout_enabled(TIMEOUT_CYCLES)) begin : g_timeout
      legup_call_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == CALL),
        .enable  (state == WAIT),
        .expired (expired)
      );
    end else begin : g_no_timeout
      assign expired = 1'b0;
    end
  endgenerate

  assign busy = (state != IDLE);

  always_comb begin
    state_next   = state;
    req_ready    = 1'b0;
    callee_start = 1'b0;
    rsp_valid    = 1'b0;
    accept       = 1'b0;
    capture      = 1'b0;
    expire       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = CALL;
        end
      end
      CALL: begin
        callee_start = 1'b1;
        if (callee_finish) begin
          capture    = 1'b1;
          state_next = DONE;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        // finish takes priority over a coincident expiry
        if (callee_finish) begin
          capture    = 1'b1;
          state_next = DONE;
        end else if (expired) begin
          expire     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      callee_arg_i <= '0;
      callee_arg_j <= '0;
      rsp_data     <= '0;
      rsp_timeout  <= 1'b0;
      call_count   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        callee_arg_i <= req_arg_i;
        callee_arg_j <= req_arg_j;
      end
      if (capture) begin
        rsp_data    <= callee_return_val;
        rsp_timeout <= 1'b0;
        call_count  <= call_count + 1'b1;
      end else if (expire) begin
        rsp_data    <= '0;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_legup_call_initiator.sv
module tb_legup_call_initiator;

  localparam int DW = 32;
  localparam int TO = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DW-1:0] req_arg_i = '0;
  logic [DW-1:0] req_arg_j = '0;
  logic          callee_start;
  logic [DW-1:0] callee_arg_i;
  logic [DW-1:0] callee_arg_j;
  logic          callee_finish;
  logic [DW-1:0] callee_return_val;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          rsp_timeout;
  logic          busy;
  logic [CW-1:0] call_count;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;

  // callee model: latency 0 = finish with start, N = finish N cycles later,
  // negative = never finishes
  int   callee_lat = 0;
  int   cd = 0;
  logic inj_finish = 1'b0;

  always #5 clk = ~clk;

  legup_call_initiator #(.DATA_W(DW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_arg_i         (req_arg_i),
    .req_arg_j         (req_arg_j),
    .callee_start      (callee_start),
    .callee_arg_i      (callee_arg_i),
    .callee_arg_j      (callee_arg_j),
    .callee_finish     (callee_finish),
    .callee_return_val (callee_return_val),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_data          (rsp_data),
    .rsp_timeout       (rsp_timeout),
    .busy              (busy),
    .call_count        (call_count)
  );

  always @(posedge clk) begin
    if (!reset) cd <= 0;
    else if (callee_start && callee_lat > 0) cd <= callee_lat;
    else if (cd > 0) cd <= cd - 1;
  end

  assign callee_finish = inj_finish | (callee_start && callee_lat == 0) | (cd == 1);
  assign callee_return_val = callee_arg_i + callee_arg_j;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] ai;
    logic [DW-1:0] aj;
    int            lat;
    int            hold;
    logic [DW-1:0] exp_data;
    logic          exp_to;
    int            exp_cyc;
  } vec_t;

  task automatic do_call(input vec_t v);
    int cyc;
    logic [DW-1:0] d0;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    callee_lat = v.lat;
    req_arg_i  = v.ai;
    req_arg_j  = v.aj;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    chk("start_pulse", callee_start, 1);
    chk("arg_i", callee_arg_i, v.ai);
    chk("arg_j", callee_arg_j, v.aj);
    while (!rsp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!rsp_valid) begin
        if (callee_start !== 1'b0) chk("start_single", callee_start, 0);
        if (req_ready !== 1'b0) chk("req_ready_busy", req_ready, 0);
        if (callee_arg_i !== v.ai) chk("arg_i_held", callee_arg_i, v.ai);
      end
    end
    chk("rsp_latency", cyc, v.exp_cyc);
    chk("rsp_data", rsp_data, v.exp_data);
    chk("rsp_timeout", rsp_timeout, v.exp_to);
    if (!v.exp_to) model_cnt = (model_cnt + 1) % (1 << CW);
    chk("call_count", call_count, model_cnt);
    d0 = rsp_data;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, d0);
      chk("hold_args", {callee_arg_i, callee_arg_j}, {v.ai, v.aj});
      chk("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle_after_hs", {busy, rsp_valid, req_ready}, 3'b001);
  endtask

  vec_t vecs[8];

  initial begin
    int n, last, cyc;
    vecs[0] = '{32'd5, 32'd7, 0, 0, 32'd12, 1'b0, 2};
    vecs[1] = '{32'hFFFF_FFFF, 32'd1, 3, 4, 32'd0, 1'b0, 5};
    vecs[2] = '{32'd100, 32'd23, 1, 0, 32'd123, 1'b0, 3};
    vecs[3] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 2, 1, 32'hFFFF_FFFF, 1'b0, 4};
    vecs[4] = '{32'd1, 32'd2, -1, 0, 32'd0, 1'b1, 10};
    vecs[5] = '{32'd3, 32'd4, 8, 0, 32'd7, 1'b0, 10};
    vecs[6] = '{32'd6, 32'd6, 7, 0, 32'd12, 1'b0, 9};
    vecs[7] = '{32'd9, 32'd1, 9, 0, 32'd0, 1'b1, 10};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_outputs", {req_ready, callee_start, rsp_valid, rsp_timeout, busy}, 5'b10000);
    chk("rst_regs", {callee_arg_i, callee_arg_j, rsp_data, 30'd0, call_count}, 0);
    reset = 1'b1;

    foreach (vecs[k]) do_call(vecs[k]);

    // timeout, then late finish pulses in DONE and IDLE are ignored
    @(negedge clk);
    callee_lat = -1;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("to_latency", cyc, 10);
    inj_finish = 1'b1;
    @(negedge clk);
    inj_finish = 1'b0;
    chk("late_fin_done", {rsp_valid, rsp_timeout, rsp_data}, {2'b11, 32'd0});
    chk("late_fin_count", call_count, model_cnt);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready  = 1'b0;
    inj_finish = 1'b1;
    @(negedge clk);
    inj_finish = 1'b0;
    @(negedge clk);
    chk("late_fin_idle", {busy, rsp_valid, req_ready}, 3'b001);
    chk("late_fin_count2", call_count, model_cnt);

    // asynchronous reset in WAIT
    callee_lat = -1;
    req_arg_i  = 32'd44;
    req_arg_j  = 32'd55;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_in_wait", busy, 1);
    #1 reset = 1'b0;
    #1;
    chk("arst_outputs", {req_ready, callee_start, rsp_valid, rsp_timeout, busy}, 5'b10000);
    chk("arst_regs", {callee_arg_i, callee_arg_j, rsp_data, 30'd0, call_count}, 0);
    model_cnt = 0;
    @(negedge clk);
    reset = 1'b1;

    // back-to-back calls: count wraps, period 3
    @(negedge clk);
    callee_lat = 0;
    req_arg_i  = 32'd1;
    req_arg_j  = 32'd1;
    req_valid  = 1'b1;
    rsp_ready  = 1'b1;
    n = 0;
    last = 0;
    for (int c = 1; c <= 30 && n < 5; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        n++;
        model_cnt = (model_cnt + 1) % (1 << CW);
        chk("wrap_count", call_count, model_cnt);
        chk("wrap_data", rsp_data, 2);
        if (n > 1) chk("wrap_period", c - last, 3);
        last = c;
        if (n == 5) req_valid = 1'b0;
      end
    end
    chk("wrap_calls", n, 5);
    @(negedge clk);
    rsp_ready = 1'b0;

    do_call('{32'd2, 32'd3, 0, 0, 32'd5, 1'b0, 2});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/legup_call_initiator.md
Name: legup_call_initiator

Overview:
- Caller-side engine for the LegUp custom-Verilog start/finish call protocol; it drives a custom function module (e.g. an adder-style callee) from a streaming request interface.
- Accepts argument pairs on a valid/ready request port and issues one start pulse with held arguments.
- Waits for finish, which may arrive in the same cycle as start or many cycles later, then captures the return value and returns it on a valid/ready response port.
- Used by hand-written glue and testbench harnesses that must call custom-Verilog functions without a generated LegUp FSM.

Parameters:
DATA_W  32  width of each argument and of the return value
TIMEOUT_CYCLES  1024  WAIT cycles before a call is abandoned; 0 disables the timeout
CNT_W  16  width of the completed-call counter

Ports:
clk  input  1  system clock; all state is on the rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
req_valid  input  1  request argument pair is valid
req_ready  output  1  initiator can accept a request
req_arg_i  input  DATA_W  first argument
req_arg_j  input  DATA_W  second argument
callee_start  output  1  one-cycle call pulse to the callee
callee_arg_i  output  DATA_W  registered first argument to the callee
callee_arg_j  output  DATA_W  registered second argument to the callee
callee_finish  input  1  callee completion; return value is valid in the same cycle
callee_return_val  input  DATA_W  callee result
rsp_valid  output  1  response is valid
rsp_ready  input  1  consumer accepts the response
rsp_data  output  DATA_W  captured return value (0 on timeout)
rsp_timeout  output  1  qualifies rsp_valid: the call timed out
busy  output  1  state != IDLE
call_count  output  CNT_W  number of successful calls, wrapping

Behaviour:
- Reset (reset==0, asynchronous):
  - state goes to IDLE.
  - Outputs forced: req_ready=1, callee_start=0, rsp_valid=0, rsp_timeout=0, busy=0.
  - Registers cleared: callee_arg_i/j=0, rsp_data=0, call_count=0, timeout counter=0.
  - Release is sampled at the next clk edge.
  - A reset asserted mid-call abandons the call immediately; no response is produced.
- States: IDLE, CALL, WAIT, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch req_arg_i/j into callee_arg_i/j, go to CALL.
- CALL:
  - callee_start=1 for exactly this cycle.
  - If callee_finish==1 this same cycle: capture callee_return_val into rsp_data, rsp_timeout<=0, increment call_count, go to DONE.
  - Otherwise clear the timeout counter and go to WAIT.
- WAIT:
  - callee_start=0.
  - On callee_finish==1: capture as in CALL, go to DONE.
  - Otherwise, when TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1: rsp_data<=0, rsp_timeout<=1, call_count unchanged, go to DONE.
  - Otherwise increment the counter.
  - If finish and timeout expiry fall in the same cycle, finish wins.
- DONE:
  - rsp_valid=1; rsp_data and rsp_timeout are held stable until rsp_ready.
  - On rsp_ready: go to IDLE.
  - req_ready=0 (no overlap between calls).
- Argument holding: callee_arg_i/j hold from acceptance until the next acceptance and are never changed during CALL/WAIT/DONE.
- callee_finish is ignored in IDLE and DONE. A late finish after a timeout is discarded.
- Latency:
  - Request accepted at edge T; callee_start is high during cycle T+1.
  - Zero-latency callee: rsp_valid is high at T+2.
  - N-cycle callee: rsp_valid is high at T+2+N.
  - Minimum call period is 3 cycles with rsp_ready tied to 1.
- call_count wraps from 2^CNT_W-1 to 0 and increments only on successful captures.

Decomposition:
- Package legup_call_pkg:
  - call_state_t enum {IDLE, CALL, WAIT, DONE};
  - default width localparams;
  - function timeout_enabled(TIMEOUT_CYCLES).
- Sub-module legup_call_timeout: clear, enable, expired; a counter sized $clog2(TIMEOUT_CYCLES+1). It is instantiated only when TIMEOUT_CYCLES!=0; otherwise expired is tied to 0.
- The FSM and datapath registers stay in the top module.

Test Plan:
- Zero-latency callee: callee_finish=callee_start, return_val=arg_i+arg_j. Request (5,7) -> callee_start is a single pulse at T+1; rsp_valid at T+2 with rsp_data=12, rsp_timeout=0, call_count=1.
- 3-cycle callee, rsp_ready held low 4 cycles, request (0xFFFFFFFF,1):
  - callee_args stay constant throughout; req_ready=0 while busy;
  - rsp_data=0 held stable until rsp_ready; back in IDLE the cycle after the handshake.
- Timeout with TIMEOUT_CYCLES=8 and a callee that never finishes -> rsp_valid with rsp_timeout=1, rsp_data=0, call_count unchanged. A finish pulse injected afterwards is ignored.
- Finish on the exact expiry cycle (TIMEOUT_CYCLES=8, finish in the 8th WAIT cycle) -> success path: rsp_timeout=0, rsp_data=return_val.
- Reset asserted (reset=0) asynchronously during WAIT -> all outputs reach their reset values without waiting for a clock edge. After release, a new request (2,3) returns 5 normally.
- Wrap: CNT_W=2, five back-to-back successful calls -> call_count sequence 1,2,3,0,1.
